// File: rtl/mult32x32_pkg.sv
// Shared types and constants for the 32x32 multiplier job scheduler.
// Optional build macro used by the scheduler: MULT_JOB_SIGNED_EN.
package mult32x32_pkg;

   localparam int OPND_W       = 32;
   localparam int PROD_W       = 64;
   localparam int MUL_BUSY_LEN = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ARM,
      S_WAIT,
      S_DONE
   } state_e;

   // Absolute value of a two's complement operand; 0x80000000 maps to itself,
   // which is the correct unsigned magnitude.
   function automatic logic [OPND_W-1:0] magnitude(input logic [OPND_W-1:0] v);
      return v[OPND_W-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/mult32x32_job_sched_fifo.sv
// Small synchronous job FIFO for the multiplier scheduler.
// Pointers carry one extra MSB so full and empty are distinguished without a counter.
module mult_job_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 68
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   // Advance the pointers on accepted pushes and pops; callers never push when full or pop when empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Storage array; contents need no reset because the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/mult32x32_job_sched.sv
// Upstream job scheduler for the 32x32 multiplier: buffers jobs, issues one start
// pulse per job, holds operands while the multiplier is busy and returns the product.
// Build macro MULT_JOB_SIGNED_EN: operands are two's complement (magnitudes go to the
// multiplier and the product sign is restored at capture).
module mult32x32_job_sched
   import mult32x32_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPND_W-1:0] in_a,
   input  logic [OPND_W-1:0] in_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              mul_start,
   output logic [OPND_W-1:0] mul_a,
   output logic [OPND_W-1:0] mul_b,
   input  logic              mul_busy,
   input  logic [PROD_W-1:0] mul_product,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] out_product,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int JOB_W = 2 * OPND_W + TAG_W;

   state_e              state_q;
   logic                mul_start_q;
   logic [OPND_W-1:0]   mul_a_q;
   logic [OPND_W-1:0]   mul_b_q;
   logic [TAG_W-1:0]    tag_q;
   logic                out_valid_q;
   logic [PROD_W-1:0]   out_product_q;
   logic [TAG_W-1:0]    out_tag_q;
`ifdef MULT_JOB_SIGNED_EN
   logic                sign_q;
   logic                sign_d;
`endif

   logic                fifoFull;
   logic                fifoEmpty;
   logic [JOB_W-1:0]    fifoHead;
   logic                fifoPush;
   logic                fifoPop;
   logic [OPND_W-1:0]   headA;
   logic [OPND_W-1:0]   headB;
   logic [TAG_W-1:0]    headTag;
   logic [OPND_W-1:0]   opA_d;
   logic [OPND_W-1:0]   opB_d;

   assign in_ready  = !fifoFull;
   assign fifoPush  = in_valid && !fifoFull;

   assign headA   = fifoHead[OPND_W-1:0];
   assign headB   = fifoHead[2*OPND_W-1:OPND_W];
   assign headTag = fifoHead[JOB_W-1:2*OPND_W];

   mult_job_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (JOB_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifoPush),
      .push_data ({in_tag, in_b, in_a}),
      .pop       (fifoPop),
      .full      (fifoFull),
      .empty     (fifoEmpty),
      .head      (fifoHead)
   );

   // Pop the head when idle, or when the finished result is being consumed so the next job starts without an idle cycle.
   always_comb begin
      fifoPop = 1'b0;
      if (!fifoEmpty) begin
         if (state_q == S_IDLE) begin
            fifoPop = 1'b1;
         end else if (state_q == S_DONE && out_ready) begin
            fifoPop = 1'b1;
         end
      end
   end

   // Operand values loaded at pop time: raw operands, or magnitudes plus product sign in signed builds.
   always_comb begin
`ifdef MULT_JOB_SIGNED_EN
      opA_d  = magnitude(headA);
      opB_d  = magnitude(headB);
      sign_d = headA[OPND_W-1] ^ headB[OPND_W-1];
`else
      opA_d  = headA;
      opB_d  = headB;
`endif
   end

   // Scheduler FSM with registered start pulse, operands and result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         mul_start_q   <= 1'b0;
         mul_a_q       <= '0;
         mul_b_q       <= '0;
         tag_q         <= '0;
         out_valid_q   <= 1'b0;
         out_product_q <= '0;
         out_tag_q     <= '0;
`ifdef MULT_JOB_SIGNED_EN
         sign_q        <= 1'b0;
`endif
      end else begin
         mul_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (fifoPop) begin
                  mul_a_q     <= opA_d;
                  mul_b_q     <= opB_d;
                  tag_q       <= headTag;
`ifdef MULT_JOB_SIGNED_EN
                  sign_q      <= sign_d;
`endif
                  mul_start_q <= 1'b1;
                  state_q     <= S_START;
               end
            end
            S_START: begin
               state_q <= S_ARM;
            end
            S_ARM: begin
               if (mul_busy) begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!mul_busy) begin
`ifdef MULT_JOB_SIGNED_EN
                  out_product_q <= sign_q ? (~mul_product + 1'b1) : mul_product;
`else
                  out_product_q <= mul_product;
`endif
                  out_tag_q     <= tag_q;
                  out_valid_q   <= 1'b1;
                  state_q       <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (fifoPop) begin
                     mul_a_q     <= opA_d;
                     mul_b_q     <= opB_d;
                     tag_q       <= headTag;
`ifdef MULT_JOB_SIGNED_EN
                     sign_q      <= sign_d;
`endif
                     mul_start_q <= 1'b1;
                     state_q     <= S_START;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign mul_start   = mul_start_q;
   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign out_valid   = out_valid_q;
   assign out_product = out_product_q;
   assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_mult32x32_job_sched.sv
// Self-checking bench for mult32x32_job_sched with a behavioural 8-cycle multiplier.
// Build macro MULT_JOB_SIGNED_EN selects the signed expectation for the mixed-sign vector.
module tb_mult32x32_job_sched;
   import mult32x32_pkg::*;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   typedef struct {
      logic [63:0]      product;
      logic [TAG_W-1:0] tag;
   } exp_t;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_a;
   logic [31:0]       in_b;
   logic [TAG_W-1:0]  in_tag;
   logic              mul_start;
   logic [31:0]       mul_a;
   logic [31:0]       mul_b;
   logic              mul_busy;
   logic [63:0]       mul_product;
   logic              out_valid;
   logic              out_ready;
   logic [63:0]       out_product;
   logic [TAG_W-1:0]  out_tag;

   exp_t   expQ[$];
   int     errors;
   int     checks;
   int     cycleCnt;
   int     lastAccept;
   int     riseCycle;
   int     startCnt;
   logic   prevValid;
   int     busyCnt;

   mult32x32_job_sched #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_tag      (in_tag),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_busy    (mul_busy),
      .mul_product (mul_product),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .out_tag     (out_tag)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used for latency measurements.
   always @(posedge clk) begin
      cycleCnt <= cycleCnt + 1;
   end

   // Multiplier model: busy rises the cycle after start, stays high 8 cycles, product lands as busy falls.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mul_busy    <= 1'b0;
         busyCnt     <= 0;
         mul_product <= '0;
      end else if (mul_start) begin
         mul_busy <= 1'b1;
         busyCnt  <= MUL_BUSY_LEN - 1;
      end else if (mul_busy) begin
         if (busyCnt == 0) begin
            mul_busy    <= 1'b0;
            mul_product <= {32'd0, mul_a} * {32'd0, mul_b};
         end else begin
            busyCnt <= busyCnt - 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, actual, expected);
      end
   endtask

   // Monitor: track start pulses and out_valid rise, and score every consumed result against the queue.
   always @(negedge clk) begin
      if (reset) begin
         prevValid <= 1'b0;
      end else begin
         if (mul_start) startCnt <= startCnt + 1;
         if (out_valid && !prevValid) riseCycle <= cycleCnt;
         prevValid <= out_valid;
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_result", {60'd0, out_tag}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("result_product", out_product, e.product);
               checkOutput("result_tag", {60'd0, out_tag}, {60'd0, e.tag});
            end
         end
      end
   end

   // Offer one job and wait (bounded) until it is accepted, queueing its expected result.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [TAG_W-1:0] tag, input logic [63:0] expProd);
      int waitCnt;
      exp_t e;
      waitCnt = 0;
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
      in_valid = 1'b1;
      while (!in_ready && waitCnt < 200) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!in_ready) begin
         checkOutput("accept_timeout", 64'd0, 64'd1);
      end else begin
         lastAccept = cycleCnt;
         e.product  = expProd;
         e.tag      = tag;
         expQ.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Wait (bounded) for out_valid to be presented.
   task automatic waitValid(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) checkOutput(name, 64'd0, 64'd1);
   endtask

   // Wait (bounded) until every expected result has been consumed.
   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (expQ.size() != 0) checkOutput(name, 64'(expQ.size()), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int s0;
      int acc;
      exp_t e;
      errors    = 0;
      checks    = 0;
      cycleCnt  = 0;
      startCnt  = 0;
      riseCycle = 0;
      lastAccept = 0;
      prevValid = 1'b0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_tag    = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("reset_mul_start", {63'd0, mul_start}, 64'd0);
      checkOutput("reset_mul_a", {32'd0, mul_a}, 64'd0);
      checkOutput("reset_mul_b", {32'd0, mul_b}, 64'd0);
      checkOutput("reset_out_product", out_product, 64'd0);
      checkOutput("reset_out_tag", {60'd0, out_tag}, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);

      // 1: single job, latency and single start pulse
      s0 = startCnt;
      applyStimulus(32'd3, 32'd5, 4'd1, 64'd15);
      waitValid("t1_valid_timeout");
      @(negedge clk);
      checkOutput("t1_latency", 64'(riseCycle - lastAccept), 64'd12);
      waitDrain("t1_drain");
      checkOutput("t1_start_pulses", 64'(startCnt - s0), 64'd1);

      // 2: all-ones operands
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 64'hFFFF_FFFE_0000_0001);
      waitDrain("t2_drain");

      // 3: fill while output is blocked; exactly 5 accepted, then in order
      out_ready = 1'b0;
      acc = 0;
      @(negedge clk);
      in_a     = 32'd1;
      in_b     = 32'd2;
      in_tag   = 4'd0;
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (in_ready && acc < 15) begin
            e.product = 64'((acc + 1) * (acc + 2));
            e.tag     = TAG_W'(acc);
            expQ.push_back(e);
            acc++;
            @(negedge clk);
            in_a   = 32'(acc + 1);
            in_b   = 32'(acc + 2);
            in_tag = TAG_W'(acc);
         end else begin
            @(negedge clk);
         end
      end
      checkOutput("t3_accepted", 64'(acc), 64'd5);
      checkOutput("t3_in_ready_full", {63'd0, in_ready}, 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      waitDrain("t3_drain");

      // 4: held result stays stable and no new start while blocked
      out_ready = 1'b0;
      applyStimulus(32'd9, 32'd9, 4'd3, 64'd81);
      applyStimulus(32'd2, 32'd2, 4'd4, 64'd4);
      waitValid("t4_valid_timeout");
      s0 = startCnt;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("t4_hold_product", out_product, 64'd81);
         checkOutput("t4_hold_tag", {60'd0, out_tag}, 64'd3);
      end
      checkOutput("t4_no_start", 64'(startCnt - s0), 64'd0);
      out_ready = 1'b1;
      waitDrain("t4_drain");

      // 5: reset during S_WAIT with two jobs queued
      applyStimulus(32'd11, 32'd11, 4'd5, 64'd121);
      s0 = lastAccept;
      applyStimulus(32'd12, 32'd12, 4'd6, 64'd144);
      applyStimulus(32'd13, 32'd13, 4'd7, 64'd169);
      while (cycleCnt < s0 + 7) @(negedge clk);
      reset = 1'b1;
      expQ.delete();
      #1;
      checkOutput("t5_reset_out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("t5_reset_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(32'd7, 32'd6, 4'd8, 64'd42);
      waitDrain("t5_drain");
      repeat (20) @(negedge clk);

      // 6: mixed-sign operands
`ifdef MULT_JOB_SIGNED_EN
      applyStimulus(32'hFFFF_FFFD, 32'd5, 4'd9, 64'hFFFF_FFFF_FFFF_FFF1);
`else
      applyStimulus(32'hFFFF_FFFD, 32'd5, 4'd9, 64'h0000_0004_FFFF_FFF1);
`endif
      waitDrain("t6_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
